alu_share_ctrl: RTL and testbench

- Sequences and arbitrates one shared 32-bit ALU (ctl 0=add, 1=sub, 2=shift-left, 3=arithmetic shift-right; A signed; shift amount taken from B[5:0]) between two requesters.
- Accepts operations over valid/ready request ports and drives the external ALU instance from registered operands.
- Captures the ALU result and returns it, tagged with the requester ID, over a valid/ready response port.
- Sits between the issue logic and the ALU datapath in the multi-cycle core.

---
 rtl/alu_share_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Purpose: arbitrates one shared 32-bit ALU between two requesters and returns tagged results.
// Latency: accept at cycle T -> resp_valid at T+2; at least 3 cycles per operation.
// Backpressure: resp_valid/resp_data/resp_id hold until resp_ready; no request is accepted until then.
//
// Ports: req0_*/req1_* valid/ready operation inputs (ctl, signed A, B);
//        alu_ctl/alu_a/alu_b drive the external ALU, alu_result is its combinational output;
//        resp_valid/resp_ready/resp_id/resp_data return the result tagged with the requester ID.
module alu_share_ctrl #(
    parameter int W         = 32,
    parameter int SHAMT_MAX = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_ctl,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_ctl,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [1:0]   alu_ctl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_data
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t       state;
    logic         last_grant;
    logic         op_id;
    logic         op_zero;     // shift-left past the word width: result forced to 0

    logic         gnt0;
    logic         gnt1;
    logic [1:0]   sel_ctl;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic         shamt_big;
    logic [W-1:0] clamp_b;
    logic         clamp_zero;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || last_grant);
        gnt1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && gnt0;
    assign req1_ready = (state == IDLE) && gnt1;

    always_comb begin
        sel_ctl = gnt1 ? req1_ctl : req0_ctl;
        sel_a   = gnt1 ? req1_a   : req0_a;
        sel_b   = gnt1 ? req1_b   : req0_b;
    end

    // The ALU only decodes shift amounts 0..31, so out-of-range shifts are
    // rewritten here: a left shift becomes a bypassed zero (alu_b=0), an
    // arithmetic right shift saturates at SHAMT_MAX, which gives the sign fill.
    always_comb begin
        shamt_big  = ({{(W-6){1'b0}}, sel_b[5:0]} > W'(SHAMT_MAX));
        clamp_b    = sel_b;
        clamp_zero = 1'b0;
        if (sel_ctl[1]) begin
            clamp_b = {{(W-6){1'b0}}, sel_b[5:0]};
            if (shamt_big) begin
                if (sel_ctl == 2'd2) begin
                    clamp_b    = '0;
                    clamp_zero = 1'b1;
                end else begin
                    clamp_b    = W'(SHAMT_MAX);
                end
            end
        end
    end

    // alu_* are the operand registers themselves: loaded on grant, valid
    // throughout EXEC and simply held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            alu_ctl    <= 2'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            op_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        alu_ctl    <= sel_ctl;
                        alu_a      <= sel_a;
                        alu_b      <= clamp_b;
                        op_id      <= gnt1;
                        op_zero    <= clamp_zero;
                        last_grant <= gnt1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= op_zero ? '0 : alu_result;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Purpose: randomized + directed scoreboard bench for alu_share_ctrl with a behavioural ALU.
// Latency: expects resp_valid two cycles after each accept.
// Backpressure: drives resp_ready low for stretches and checks held responses.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_ctl, req1_ctl, alu_ctl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_a, alu_b, alu_result, resp_data;
    logic        resp_valid, resp_ready, resp_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    alu_share_ctrl #(.W(32), .SHAMT_MAX(31)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External ALU: garbage for shift amounts it does not decode.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_ctl)
            2'd0: alu_result = alu_a + alu_b;
            2'd1: alu_result = alu_a - alu_b;
            2'd2: if (alu_b[5:0] < 6'd32) alu_result = alu_a << alu_b[5:0];
            default: if (alu_b[5:0] < 6'd32) alu_result = $unsigned($signed(alu_a) >>> alu_b[5:0]);
        endcase
    end

    function automatic logic [31:0] ref_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[5:0]);
        case (c)
            2'd0: ref_op = a + b;
            2'd1: ref_op = a - b;
            2'd2: ref_op = (sh >= 32) ? 32'd0 : (a << sh);
            default: ref_op = (sh >= 32) ? {32{a[31]}} : $unsigned($signed(a) >>> sh);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   busy     = 0;
    bit   lg       = 1;
    bit   in_resp  = 0;
    bit   drop_nxt = 0;
    bit   post_rst = 0;

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        bit e0, e1;
        if (rst) begin
            q.delete();
            busy = 0; lg = 1; in_resp = 0; drop_nxt = 0; post_rst = 1;
        end else begin
            if (post_rst) begin
                chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
                post_rst = 0;
            end
            if (drop_nxt) begin
                chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
                drop_nxt = 0;
            end
            e0 = !busy && req0_valid && (!req1_valid || lg);
            e1 = !busy && req1_valid && (!req0_valid || !lg);
            chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, e1, e0});
            chk("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_valid && req0_ready) begin
                q.push_back('{id: 1'b0, data: ref_op(req0_ctl, req0_a, req0_b), t: cyc});
                lg = 0; busy = 1;
            end else if (req1_valid && req1_ready) begin
                q.push_back('{id: 1'b1, data: ref_op(req1_ctl, req1_a, req1_b), t: cyc});
                lg = 1; busy = 1;
            end
            if (resp_valid) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("resp_id", {31'd0, resp_id}, {31'd0, cur.id});
                        chk("resp_data", resp_data, cur.data);
                        chk("latency", cyc - cur.t, 32'd2);
                        in_resp = 1;
                    end
                end else begin
                    chk("hold_id", {31'd0, resp_id}, {31'd0, cur.id});
                    chk("hold_data", resp_data, cur.data);
                end
                if (resp_ready) begin
                    in_resp = 0; busy = 0; drop_nxt = 1;
                end
            end else if (q.size() != 0 && cyc > q[0].t + 2) begin
                chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
                q.delete();
                busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        if (!id) begin
            req0_valid = 1'b1; req0_ctl = c; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_ctl = c; req1_a = a; req1_b = b;
        end
    endtask

    // Presents one operation and holds it until accepted (bounded).
    task automatic issue(input bit id, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 0;
        set_req(id, c, a, b);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
            tick();
        end
        if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (!got) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (q.size() == 0) && !busy;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_req(input bit id);
        set_req(id, 2'($urandom_range(0, 3)), $urandom, $urandom);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp_ready = 1'b1;
        req0_ctl = 0; req0_a = 0; req0_b = 0;
        req1_ctl = 0; req1_a = 0; req1_b = 0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_alu_ctl", {30'd0, alu_ctl}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        tick();

        // Directed operations, including the shift clamp boundaries.
        issue(0, 2'd0, 32'd5, 32'd7);                 wait_idle();
        issue(1, 2'd1, 32'd3, 32'd5);                 wait_idle();
        issue(0, 2'd3, 32'h8000_0000, 32'd4);         wait_idle();
        issue(1, 2'd3, 32'h8000_0000, 32'd63);        wait_idle();
        issue(0, 2'd2, 32'd1, 32'd40);                wait_idle();
        issue(1, 2'd2, 32'd1, 32'd31);                wait_idle();
        issue(0, 2'd3, 32'h7000_0000, 32'hFFFF_FFE0); wait_idle();
        issue(1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0100); wait_idle();

        // Continuous contention: grants must alternate.
        for (int i = 0; i < 40; i++) begin
            rand_req(0);
            rand_req(1);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        // Backpressure: hold the response, with requester 1 waiting.
        resp_ready = 1'b0;
        issue(0, 2'd0, 32'hFFFF_FFFF, 32'd2);
        set_req(1, 2'd1, 32'd10, 32'd20);
        repeat (5) tick();
        resp_ready = 1'b1;
        issue(1, 2'd1, 32'd10, 32'd20);
        wait_idle();

        // Reset during EXEC, then a tie must go to requester 0.
        issue(1, 2'd0, 32'd100, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1, 2'd0, 32'd1, 32'd1);
        issue(0, 2'd0, 32'd2, 32'd2);
        issue(1, 2'd0, 32'd1, 32'd1);
        wait_idle();

        // Random traffic with random backpressure and withdrawn requests.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) rand_req(0); else req0_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) rand_req(1); else req1_valid = 1'b0;
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0; resp_ready = 1'b1;
        wait_idle();
        chk("sb_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
